// File: rtl/digit_counter_chain.sv
// Chained BCD digit counter: each digit ripples its carry one digit per clock, and count_out is
// refreshed only with fully settled values.
module digit_counter_chain #(
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc_clk,
    input  logic                  ref_clk,
    input  logic [DIGITS-1:0]     inc_sel,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  busy,
    output logic                  overflow,
    output logic                  missed
);

    logic [DIGITS-1:0][3:0] live_q, live_d;
    logic [DIGITS-1:0][3:0] count_q, count_d;
    logic [DIGITS-1:0]      carry_q, carry_d;
    logic [DIGITS-1:0]      carry_out;
    logic                   refresh_pend_q, refresh_pend_d;
    logic                   overflow_q, overflow_d;
    logic                   missed_q, missed_d;
    logic                   inc_go;
    logic                   refresh_now;

    assign busy      = |carry_q;
    assign count_out = count_q;
    assign overflow  = overflow_q;
    assign missed    = missed_q;
    assign inc_go    = inc_clk && !busy;

    always_comb begin
        live_d    = live_q;
        carry_out = '0;
        for (int d = 0; d < DIGITS; d++) begin
            // A digit is bumped either by an accepted increment or by a pending carry, never both.
            if (carry_q[d] || (inc_go && inc_sel[d])) begin
                if (live_q[d] == 4'd9) begin
                    live_d[d]    = 4'd0;
                    carry_out[d] = 1'b1;
                end else begin
                    live_d[d] = live_q[d] + 4'd1;
                end
            end
        end
        carry_d    = carry_out << 1;
        overflow_d = overflow_q || carry_out[DIGITS-1];
        missed_d   = missed_q || (inc_clk && busy);
    end

    always_comb begin
        count_d        = count_q;
        refresh_pend_d = refresh_pend_q;
        // Copy only when nothing is pending and this edge generates no new carry.
        refresh_now = (ref_clk && !busy && !inc_clk) ||
                      (refresh_pend_q && !busy && (carry_d == '0));
        if (refresh_now) begin
            count_d        = live_d;
            refresh_pend_d = 1'b0;
        end else if (ref_clk) begin
            refresh_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q         <= '0;
            count_q        <= '0;
            carry_q        <= '0;
            refresh_pend_q <= 1'b0;
            overflow_q     <= 1'b0;
            missed_q       <= 1'b0;
        end else begin
            live_q         <= live_d;
            count_q        <= count_d;
            carry_q        <= carry_d;
            refresh_pend_q <= refresh_pend_d;
            overflow_q     <= overflow_d;
            missed_q       <= missed_d;
        end
    end

endmodule

// File: tb/tb_digit_counter_chain.sv
// Directed bench for digit_counter_chain: increments, carry ripple, deferred refresh,
// overflow, missed increments and reset mid-ripple.
module tb_digit_counter_chain;

    localparam int unsigned DIGITS = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                inc_clk = 1'b0;
    logic                ref_clk = 1'b0;
    logic [DIGITS-1:0]   inc_sel = '0;
    logic [4*DIGITS-1:0] count_out;
    logic                busy;
    logic                overflow;
    logic                missed;

    int total = 0;
    int bad   = 0;

    digit_counter_chain #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .inc_clk   (inc_clk),
        .ref_clk   (ref_clk),
        .inc_sel   (inc_sel),
        .count_out (count_out),
        .busy      (busy),
        .overflow  (overflow),
        .missed    (missed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inc(input logic [DIGITS-1:0] sel);
        inc_clk = 1'b1;
        inc_sel = sel;
        step();
        inc_clk = 1'b0;
        inc_sel = '0;
    endtask

    task automatic bump(input logic [DIGITS-1:0] sel, input int n);
        repeat (n) inc(sel);
    endtask

    task automatic refresh();
        ref_clk = 1'b1;
        step();
        ref_clk = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check_eq("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        bit busy_seen;

        // Reset state
        do_reset();
        check_eq("rst_count", 32'(count_out), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_missed", 32'(missed), 32'd0);

        // Single increment, refresh 10 cycles later, busy never set
        busy_seen = 1'b0;
        inc(6'b000001);
        for (int i = 0; i < 10; i++) begin
            busy_seen |= busy;
            step();
        end
        check_eq("single_busy", 32'(busy_seen), 32'd0);
        check_eq("single_stale", 32'(count_out), 32'h0);
        refresh();
        check_eq("single_count", 32'(count_out), 32'h000001);

        // 099999 + 1: five busy cycles, then 100000
        do_reset();
        bump(6'b011111, 9);
        refresh();
        check_eq("pre_099999", 32'(count_out), 32'h099999);
        inc(6'b000001);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("ripple5_busy%0d", i), 32'(busy), 32'd1);
            check_eq($sformatf("ripple5_hold%0d", i), 32'(count_out), 32'h099999);
            step();
        end
        check_eq("ripple5_done", 32'(busy), 32'd0);
        refresh();
        check_eq("ripple5_count", 32'(count_out), 32'h100000);

        // 999999 + 1 wraps and sets sticky overflow
        do_reset();
        bump(6'b111111, 9);
        refresh();
        check_eq("pre_999999", 32'(count_out), 32'h999999);
        check_eq("pre_ovf", 32'(overflow), 32'd0);
        inc(6'b000001);
        wait_idle();
        check_eq("wrap_ovf", 32'(overflow), 32'd1);
        refresh();
        check_eq("wrap_count", 32'(count_out), 32'h000000);
        inc(6'b000001);
        refresh();
        check_eq("post_wrap_count", 32'(count_out), 32'h000001);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);
        check_eq("wrap_missed", 32'(missed), 32'd0);

        // 000009 with inc_sel=000011 -> 000020; inc_sel=0 changes nothing
        do_reset();
        bump(6'b000001, 9);
        inc(6'b000000);
        refresh();
        check_eq("pre_000009", 32'(count_out), 32'h000009);
        inc(6'b000011);
        check_eq("dual_busy", 32'(busy), 32'd1);
        step();
        check_eq("dual_idle", 32'(busy), 32'd0);
        refresh();
        check_eq("dual_count", 32'(count_out), 32'h000020);

        // Refresh one cycle after a 3-digit ripple is deferred, no intermediate value shown
        do_reset();
        bump(6'b000111, 9);
        refresh();
        check_eq("pre_000999", 32'(count_out), 32'h000999);
        inc(6'b000001);
        refresh();
        check_eq("defer_hold1", 32'(count_out), 32'h000999);
        check_eq("defer_busy1", 32'(busy), 32'd1);
        refresh();
        check_eq("defer_hold2", 32'(count_out), 32'h000999);
        step();
        check_eq("defer_hold3", 32'(count_out), 32'h000999);
        check_eq("defer_busy3", 32'(busy), 32'd0);
        step();
        check_eq("defer_count", 32'(count_out), 32'h001000);
        step();
        check_eq("defer_stable", 32'(count_out), 32'h001000);

        // Increment while busy is discarded and flagged
        do_reset();
        bump(6'b000111, 9);
        inc(6'b000001);
        inc(6'b000001);
        check_eq("missed_set", 32'(missed), 32'd1);
        wait_idle();
        refresh();
        check_eq("missed_count", 32'(count_out), 32'h001000);
        inc(6'b000001);
        refresh();
        check_eq("missed_sticky", 32'(missed), 32'd1);
        check_eq("missed_counts_on", 32'(count_out), 32'h001001);

        // Asynchronous reset mid-ripple with a refresh pending
        do_reset();
        bump(6'b000111, 9);
        refresh();
        inc(6'b000001);
        refresh();
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_count", 32'(count_out), 32'h0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_missed", 32'(missed), 32'd0);
        step();
        reset = 1'b0;
        step();
        step();
        check_eq("arst_no_refresh", 32'(count_out), 32'h0);
        check_eq("arst_idle", 32'(busy), 32'd0);
        refresh();
        check_eq("arst_live_zero", 32'(count_out), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_counter_chain.md
DIGIT_COUNTER_CHAIN -- requirements
Module: digit_counter_chain

Interface
REQ-001 SHALL have parameter: DIGITS, default 6, number of BCD digits (legal range 1..8).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  system reset, asynchronous and active-high.
REQ-004 SHALL have port: inc_clk  input  1  single-cycle increment strobe from the trigger/debounce block.
REQ-005 SHALL have port: ref_clk  input  1  single-cycle output-refresh strobe from the trigger/debounce block.
REQ-006 SHALL have port: inc_sel  input  DIGITS  digit-select bits; bit d requests +1 at digit d; sampled only when inc_clk=1.
REQ-007 SHALL have port: count_out  output  4*DIGITS  refreshed display value; digit d occupies bits [4d+3:4d].
REQ-008 SHALL have port: busy  output  1  high while any carry is pending.
REQ-009 SHALL have port: overflow  output  1  sticky; set when the top digit carries out.
REQ-010 SHALL have port: missed  output  1  sticky; set when an inc_clk is discarded.

Function
REQ-011 SHALL hold an internal live register of DIGITS BCD digits, each always in 0..9.
REQ-012 SHALL hold a DIGITS-bit carry_pend vector; busy SHALL equal the OR of carry_pend.
REQ-013 SHALL, on inc_clk=1 with busy=0, add 1 to every digit d with inc_sel[d]=1 in that same edge.
REQ-014 SHALL, for each such digit at 9, write 0 and set carry_pend[d+1]; at d=DIGITS-1, set overflow instead.
REQ-015 SHALL, on each edge with carry_pend[d]=1, add 1 to digit d and clear carry_pend[d].
REQ-016 SHALL, when that carry takes digit d from 9 to 0, set carry_pend[d+1] for the next edge; at d=DIGITS-1, set overflow instead.
REQ-017 SHALL therefore ripple carries one digit per cycle; worst case is DIGITS-1 cycles after inc_clk.
REQ-018 SHALL ignore inc_clk=1 while busy=1, leave live unchanged, and set missed.
REQ-019 SHALL ignore inc_sel when inc_clk=0; inc_clk=1 with inc_sel=0 SHALL change nothing.
REQ-020 SHALL wrap from all-9s to all-0s on a full carry chain, with overflow set.
REQ-021 SHALL, on ref_clk=1 with busy=0 and no inc_clk in the same cycle, copy live to count_out on that edge.
REQ-022 SHALL, on ref_clk=1 otherwise, set refresh_pend.
REQ-023 SHALL, while refresh_pend=1, copy live to count_out on the first edge after busy returns to 0, then clear refresh_pend.
REQ-024 SHALL define "busy returns to 0" as carry_pend all-zero and no carry generated on that edge.
REQ-025 SHALL keep count_out stable at every other time.
REQ-026 SHALL NOT copy a partially rippled value to count_out.
REQ-027 SHALL treat additional ref_clk pulses while refresh_pend=1 as a single pending refresh.
REQ-028 SHALL keep overflow and missed set until reset; they SHALL NOT affect counting.

Reset
REQ-029 SHALL, while reset=1, force live, count_out, carry_pend and refresh_pend to 0, and busy, overflow and missed to 0.
REQ-030 SHALL, on reset asserted mid-ripple or with a refresh pending, discard all pending work immediately.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-032 SHALL be verified: reset, inc_clk with inc_sel=000001, ref_clk 10 cycles later -> count_out=000001, busy never set.
REQ-033 SHALL be verified: live=099999, inc_sel=000001 -> busy high 5 cycles; carries reach digit 5 on the 5th edge after inc; then ref -> count_out=100000.
REQ-034 SHALL be verified: live=999999, inc_sel=000001 -> after ripple, live=000000 and overflow=1; overflow stays 1 after further incs.
REQ-035 SHALL be verified: live=000009, inc_sel=000011 -> digit0=0 and digit1=1 on capture, then digit1=2 after 1 cycle -> 000020.
REQ-036 SHALL be verified: ref_clk 1 cycle after an inc that ripples 3 digits -> count_out unchanged until busy drops, then shows the final value; no intermediate value appears.
REQ-037 SHALL be verified: inc_clk during busy -> missed=1, final count reflects the first inc only; reset mid-ripple -> all outputs 0 next cycle.
